reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset sequencer for the post-PLL clock domain. It qualifies an asynchronous PLL lock indication, then releases a set of CHANNELS active-high reset outputs one at a time, STAGE_LEN cycles apart, in index order. Any loss of lock or a soft reset request returns every channel to reset and restarts the sequence. It drives the reset inputs of downstream subsystems that must come out of reset in a fixed order.

## Interface
- CHANNELS, 4: number of sequenced reset outputs; ≥1.
- STAGE_LEN, 8: cycles between consecutive channel releases; ≥1.
- LOCK_FILTER, 4: consecutive synchronised lock-high samples required before sequencing starts; ≥1.
- CNT_WIDTH, 8: width of the lock-loss counter; ≥1.

- clock  in  1  PLL output clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; returns the whole block to its reset state.
- pll_lock  in  1  PLL lock, asynchronous to clock; double-flop synchronised internally (lock_s).
- soft_reset  in  1  synchronous, active-high request to restart the sequence.
- reset_out  out  CHANNELS  active-high per-channel resets; bit 0 is released first.
- ready  out  1  high when every channel is released (state RUN).
- lock_loss_count  out  CNT_WIDTH  saturating count of lock losses seen in RELEASE or RUN.

## Operation
- Reset values: reset_out all ones, ready 0, lock_loss_count 0, both sync flops 0, filter and stage counters 0, channel index 0, state HOLD.
- HOLD: all reset_out high. filt_cnt increments on each lock_s=1 sample and clears on any lock_s=0 sample. When a sample makes filt_cnt reach LOCK_FILTER, the next state is RELEASE with stage_cnt=0 and idx=0.
- RELEASE: stage_cnt counts 0..STAGE_LEN-1. On the edge where stage_cnt=STAGE_LEN-1, reset_out[idx] clears, stage_cnt returns to 0, and idx increments. Released bits stay low. When idx=CHANNELS-1 is released, the next state is RUN and ready rises on the same edge.
- RUN: reset_out all zero, ready 1. The block stays here until an abort.
- Abort (any state): lock_s=0 or soft_reset=1 → HOLD on that edge. All reset_out go high, ready goes 0, and filt_cnt, stage_cnt and idx clear.
- lock_loss_count increments only when the abort cause is lock_s=0 and the current state is RELEASE or RUN. It saturates at 2^CNT_WIDTH−1. A soft_reset abort never increments it. If soft_reset and a lock loss occur on the same edge, the counter increments (lock loss takes precedence for counting).
- soft_reset held high keeps the block in HOLD with filt_cnt at 0.
- reset has priority over everything else, and it also clears lock_loss_count.

## Timing
- Let E0 be the first edge that samples pll_lock=1. lock_s is high after E1. State is RELEASE after E(1+LOCK_FILTER).
- reset_out[i] falls after edge E(1+LOCK_FILTER+STAGE_LEN·(i+1)). ready rises on the same edge as reset_out[CHANNELS−1] falls.
- Lock-loss latency: pll_lock=0 sampled at L0 gives lock_s=0 after L1, and all reset_out high plus the counter update after L2.
- soft_reset latency: outputs reassert after the edge that samples soft_reset=1.
- A lock-low glitch shorter than one sample period may be missed. This is acceptable; no minimum pulse width is guaranteed.
- Outputs are registered, so there is no combinational path from inputs to outputs.

## Configuration
- RESET_SEQ_LOCK_FILTER_EN defined: the lock filter operates as described above with LOCK_FILTER.
- Not defined: the filter is removed and the LOCK_FILTER parameter is ignored. The block behaves exactly as LOCK_FILTER=1, with RELEASE entered on the edge after lock_s first samples high, i.e. after E2.

## Test plan
- Defaults, macro defined, reset for 3 cycles, then pll_lock=1 from E0 → reset_out = 4'b1111 through E12. Bits 0..3 fall after E13, E21, E29 and E37. ready rises after E37. Count stays 0.
- Lock glitch during filter: pll_lock low for exactly the one edge E2 → filt_cnt clears, sequencing restarts with no release before E(2+…) shifted. reset_out[0] falls 3 cycles later than in the previous scenario. Count stays 0.
- Lock loss in RUN: drop pll_lock at L0 → reset_out=4'b1111 and ready=0 after L2, and the count goes 0→1. Re-lock and the full sequence repeats.
- soft_reset pulse in RELEASE after bit 1 is released → all bits high on the next edge, count unchanged, and the sequence restarts from bit 0.
- Saturation: with CNT_WIDTH=2, run 5 lock-loss cycles from RUN → count reads 1, 2, 3, 3, 3.
- Macro undefined, LOCK_FILTER=4 → reset_out[0] falls after E10 (= E2+8). reset asserted mid-RELEASE clears the count and forces 4'b1111 on the next edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Post-PLL reset sequencer: qualifies PLL lock, then releases CHANNELS resets in index order.
// Define RESET_SEQ_LOCK_FILTER_EN to enable the LOCK_FILTER-sample lock qualifier.
module reset_sequencer #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned STAGE_LEN   = 8,
    parameter int unsigned LOCK_FILTER = 4,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pll_lock,
    input  logic                 soft_reset,
    output logic [CHANNELS-1:0]  reset_out,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] lock_loss_count
);

    localparam int unsigned STAGE_W = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
    localparam int unsigned IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int unsigned FILT_W  = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
`endif

    typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 lock_s;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CHANNELS-1:0]  rst_q, rst_d;
    logic                 ready_q, ready_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    logic [FILT_W-1:0]    filt_q, filt_d;
`endif

    assign lock_s          = sync_q[1];
    assign reset_out       = rst_q;
    assign ready           = ready_q;
    assign lock_loss_count = cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= StHold;
            stage_q <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cnt_q   <= '0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
            filt_q  <= '0;
`endif
        end else begin
            sync_q  <= {sync_q[0], pll_lock};
            state_q <= state_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
`ifdef RESET_SEQ_LOCK_FILTER_EN
            filt_q  <= filt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
`ifdef RESET_SEQ_LOCK_FILTER_EN
        filt_d  = filt_q;
`endif

        if (!lock_s || soft_reset) begin
            state_d = StHold;
            stage_d = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
            filt_d  = '0;
`endif
            // Lock loss is counted even when a soft reset coincides with it.
            if (!lock_s && (state_q != StHold) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else begin
            unique case (state_q)
                StHold: begin
                    rst_d   = '1;
                    ready_d = 1'b0;
`ifdef RESET_SEQ_LOCK_FILTER_EN
                    if (filt_q == FILT_W'(LOCK_FILTER - 1)) begin
                        state_d = StRelease;
                        filt_d  = '0;
                        stage_d = '0;
                        idx_d   = '0;
                    end else begin
                        filt_d = filt_q + FILT_W'(1);
                    end
`else
                    state_d = StRelease;
                    stage_d = '0;
                    idx_d   = '0;
`endif
                end
                StRelease: begin
                    if (stage_q == STAGE_W'(STAGE_LEN - 1)) begin
                        stage_d       = '0;
                        rst_d[idx_q]  = 1'b0;
                        if (idx_q == IDX_W'(CHANNELS - 1)) begin
                            state_d = StRun;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                    end
                end
                StRun: begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
                default: state_d = StHold;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a CNT_WIDTH=2 instance for saturation.
// Expected timing follows RESET_SEQ_LOCK_FILTER_EN (filter length LF when defined, 1 otherwise).
module tb_reset_sequencer;

    localparam int CH   = 4;
    localparam int SL   = 8;
    localparam int LF   = 4;
`ifdef RESET_SEQ_LOCK_FILTER_EN
    localparam int F    = LF;
`else
    localparam int F    = 1;
`endif
    // RELEASE is entered after edge E(1+F) when lock rises before E0.
    localparam int R0   = 1 + F;
    localparam int DONE = SL * CH;

    logic          clock = 1'b0;
    logic          reset;
    logic          pll_lock;
    logic          soft_reset;
    logic [CH-1:0] reset_out, reset_out_sat;
    logic          ready, ready_sat;
    logic [7:0]    cnt;
    logic [1:0]    cnt_sat;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    reset_sequencer #(
        .CHANNELS(CH), .STAGE_LEN(SL), .LOCK_FILTER(LF), .CNT_WIDTH(8)
    ) dut (
        .clock(clock), .reset(reset), .pll_lock(pll_lock), .soft_reset(soft_reset),
        .reset_out(reset_out), .ready(ready), .lock_loss_count(cnt)
    );

    reset_sequencer #(
        .CHANNELS(CH), .STAGE_LEN(SL), .LOCK_FILTER(LF), .CNT_WIDTH(2)
    ) dut_sat (
        .clock(clock), .reset(reset), .pll_lock(pll_lock), .soft_reset(soft_reset),
        .reset_out(reset_out_sat), .ready(ready_sat), .lock_loss_count(cnt_sat)
    );

    always #5 clock = ~clock;

    // Expected {reset_out, ready} after edge k when RELEASE was entered after edge r.
    function automatic logic [CH:0] exp_out(input int r, input int k);
        logic [CH-1:0] v;
        v = '1;
        for (int i = 0; i < CH; i++) begin
            if (k >= r + SL * (i + 1)) v[i] = 1'b0;
        end
        return {v, (k >= r + DONE)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        pll_lock = 1'b0;
        soft_reset = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Next edge becomes E0.
    task automatic start_lock();
        pll_lock = 1'b1;
        edge_n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pll_lock = 1'b1;
        soft_reset = 1'b0;
        repeat (4) tick();
        n_vec++;
        if ({reset_out, ready} !== 5'b11110) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", {reset_out, ready}, 5'b11110);
        end
        n_vec++;
        if ({cnt, cnt_sat} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d/%0d want 0/0", cnt, cnt_sat);
        end
        n_vec++;
        if ({reset_out_sat, ready_sat} !== 5'b11110) begin
            n_err++;
            $display("FAIL reset_outputs_sat: got %b want %b", {reset_out_sat, ready_sat}, 5'b11110);
        end
        reset = 1'b0;
        pll_lock = 1'b0;
    endtask

    task automatic test_sequence();
        logic [CH:0] e;
        apply_reset();
        start_lock();
        while (edge_n < R0 + DONE + 2) begin
            tick();
            e = exp_out(R0, edge_n);
            n_vec++;
            if ({reset_out, ready, reset_out_sat, ready_sat} !== {e, e}) begin
                n_err++;
                $display("FAIL sequence E%0d: got %b/%b want %b", edge_n, {reset_out, ready},
                         {reset_out_sat, ready_sat}, e);
            end
        end
        n_vec++;
        if (cnt !== 8'd0) begin
            n_err++;
            $display("FAIL sequence_count: got %0d want 0", cnt);
        end
    endtask

    task automatic test_lock_glitch();
        logic [CH:0] e;
        int          exp_cnt;
        exp_cnt = (F == 1) ? 1 : 0;
        apply_reset();
        start_lock();
        tick();
        tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        while (edge_n < R0 + 3 + DONE + 1) begin
            tick();
            e = exp_out(R0 + 3, edge_n);
            n_vec++;
            if ({reset_out, ready} !== e) begin
                n_err++;
                $display("FAIL glitch E%0d: got %b want %b", edge_n, {reset_out, ready}, e);
            end
        end
        n_vec++;
        if (cnt !== 8'(exp_cnt)) begin
            n_err++;
            $display("FAIL glitch_count: got %0d want %0d", cnt, exp_cnt);
        end
    endtask

    task automatic test_lock_loss_run();
        logic [CH:0] e;
        apply_reset();
        start_lock();
        while (edge_n < R0 + DONE) tick();
        n_vec++;
        if ({reset_out, ready} !== 5'b00001) begin
            n_err++;
            $display("FAIL loss_in_run: got %b want %b", {reset_out, ready}, 5'b00001);
        end
        pll_lock = 1'b0;
        for (int l = 0; l < 2; l++) begin
            tick();
            n_vec++;
            if ({reset_out, ready} !== 5'b00001) begin
                n_err++;
                $display("FAIL loss_L%0d: got %b want %b", l, {reset_out, ready}, 5'b00001);
            end
        end
        tick();
        n_vec++;
        if ({reset_out, ready, cnt} !== {5'b11110, 8'd1}) begin
            n_err++;
            $display("FAIL loss_L2: got %b cnt %0d want 11110 cnt 1", {reset_out, ready}, cnt);
        end
        start_lock();
        while (edge_n < R0 + DONE + 1) begin
            tick();
            e = exp_out(R0, edge_n);
            n_vec++;
            if ({reset_out, ready} !== e) begin
                n_err++;
                $display("FAIL relock E%0d: got %b want %b", edge_n, {reset_out, ready}, e);
            end
        end
        n_vec++;
        if (cnt !== 8'd1) begin
            n_err++;
            $display("FAIL relock_count: got %0d want 1", cnt);
        end
    endtask

    task automatic test_soft_reset();
        logic [CH:0] e;
        int          r;
        apply_reset();
        start_lock();
        while (edge_n < R0 + 2 * SL) tick();
        n_vec++;
        if ({reset_out, ready} !== 5'b11000) begin
            n_err++;
            $display("FAIL soft_pre: got %b want %b", {reset_out, ready}, 5'b11000);
        end
        soft_reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_vec++;
            if ({reset_out, ready, cnt} !== {5'b11110, 8'd0}) begin
                n_err++;
                $display("FAIL soft_hold%0d: got %b cnt %0d want 11110 cnt 0", s,
                         {reset_out, ready}, cnt);
            end
        end
        soft_reset = 1'b0;
        r = edge_n + F;
        while (edge_n < r + DONE + 1) begin
            tick();
            e = exp_out(r, edge_n);
            n_vec++;
            if ({reset_out, ready} !== e) begin
                n_err++;
                $display("FAIL soft_restart E%0d: got %b want %b", edge_n, {reset_out, ready}, e);
            end
        end
        n_vec++;
        if (cnt !== 8'd0) begin
            n_err++;
            $display("FAIL soft_count: got %0d want 0", cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_sat;
        apply_reset();
        for (int j = 1; j <= 5; j++) begin
            start_lock();
            while (edge_n < R0 + DONE) tick();
            n_vec++;
            if ({ready, ready_sat} !== 2'b11) begin
                n_err++;
                $display("FAIL sat_run%0d: got %b want 11", j, {ready, ready_sat});
            end
            pll_lock = 1'b0;
            repeat (3) tick();
            exp_sat = (j > 3) ? 3 : j;
            n_vec++;
            if (cnt !== 8'(j) || cnt_sat !== 2'(exp_sat)) begin
                n_err++;
                $display("FAIL sat_count%0d: got %0d/%0d want %0d/%0d", j, cnt, cnt_sat, j, exp_sat);
            end
        end
    endtask

    task automatic test_reset_mid_release();
        apply_reset();
        start_lock();
        while (edge_n < R0 + DONE) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (cnt !== 8'd1) begin
            n_err++;
            $display("FAIL mid_pre_count: got %0d want 1", cnt);
        end
        start_lock();
        while (edge_n < R0 + SL + 2) tick();
        n_vec++;
        if ({reset_out, ready} !== 5'b11100) begin
            n_err++;
            $display("FAIL mid_release: got %b want %b", {reset_out, ready}, 5'b11100);
        end
        reset = 1'b1;
        for (int h = 0; h < 2; h++) begin
            tick();
            n_vec++;
            if ({reset_out, ready, cnt, cnt_sat} !== {5'b11110, 8'd0, 2'd0}) begin
                n_err++;
                $display("FAIL mid_reset%0d: got %b cnt %0d/%0d want 11110 cnt 0/0", h,
                         {reset_out, ready}, cnt, cnt_sat);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pll_lock = 1'b0;
        soft_reset = 1'b0;
        test_reset();
        test_sequence();
        test_lock_glitch();
        test_lock_loss_run();
        test_soft_reset();
        test_saturation();
        test_reset_mid_release();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
